// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: feeds one 4-bit combinational adder one
// nibble per cycle, ripples the carry in a register and assembles the sum.
// Ports:
//   clk, rst (sync, active-high)
//   start, op_a, op_b, cin  : request; sampled when accepted in IDLE/DONE
//   busy, done, sum, cout   : status and held result
//   adder_a/b/cin -> adder  : nibble operands (zero outside RUN)
//   adder_s/cout  <- adder  : nibble result, captured the same cycle
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           adder_a,
  output logic [3:0]           adder_b,
  output logic                 adder_cin,
  input  logic [3:0]           adder_s,
  input  logic                 adder_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            w_accept;
  logic            w_last;
  logic [IW+1:0]   w_sel;

  assign w_last = (r_idx == IW'(NIBBLES - 1));
  assign w_sel  = {r_idx, 2'b00};

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        // Back-to-back start is taken here with no idle bubble.
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (r_state == S_RUN) begin
      adder_a   = r_a[w_sel +: 4];
      adder_b   = r_b[w_sel +: 4];
      adder_cin = r_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_carry <= cin;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_sum[w_sel +: 4] <= adder_s;
        r_carry           <= adder_cout;
        if (w_last) begin
          r_cout <= adder_cout;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl with NIBBLES=4 and a behavioural
// 4-bit adder closing the loop on the adder ports.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  adder_a;
  logic [3:0]  adder_b;
  logic        adder_cin;
  logic [3:0]  adder_s;
  logic        adder_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {adder_cout, adder_s} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] esum;
    logic        ecout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry entering nibble k is the carry out of the low 4k bits.
  function automatic logic [3:0] ref_carries(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic c);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      int unsigned m;
      int unsigned t;
      m = (32'd1 << (4 * k)) - 1;
      t = (a & m) + (b & m) + c;
      r[k] = (t >> (4 * k)) & 1;
    end
    return r;
  endfunction

  function automatic logic [16:0] ref_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  // Caller is at #1 after an edge in IDLE or DONE. Returns in the done cycle.
  task automatic run_add(input logic [15:0] a, input logic [15:0] b,
                         input logic c, output logic [15:0] s,
                         output logic co, output int nbusy, output int lat,
                         output logic [3:0] cseq, output logic [15:0] s0,
                         output logic b0);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = c;
    step();
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    cin   = 1'($urandom);
    s0    = sum;
    b0    = busy;
    lat   = 1;
    nbusy = 0;
    cseq  = '0;
    while (!done && lat < 20) begin
      if (busy) begin
        if (nbusy < 4) cseq[nbusy] = adder_cin;
        nbusy++;
      end
      step();
      lat++;
    end
    s  = sum;
    co = cout;
  endtask

  logic [15:0] s, s0, last_sum;
  logic        co, b0, last_cout;
  logic [3:0]  cseq;
  logic [16:0] exp17;
  int          nb, lat, pulses, bad;

  initial begin
    vecs[0] = '{16'h0009, 16'h000B, 1'b0, 16'h0014, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0002, 16'h0002, 1'b1, 16'h0005, 1'b0};
    vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_adder", {adder_a, adder_b, adder_cin}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].c, s, co, nb, lat, cseq, s0, b0);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].esum);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].ecout);
      chk($sformatf("vec%0d_lat", i), lat, 5);
      chk($sformatf("vec%0d_busy", i), nb, 4);
      chk($sformatf("vec%0d_cinseq", i), cseq,
          ref_carries(vecs[i].a, vecs[i].b, vecs[i].c));
      step();
      chk($sformatf("vec%0d_pulse", i), {busy, done}, 0);
    end

    // Explicit ripple sequence 0,1,1,1 for FFFF+1.
    run_add(16'hFFFF, 16'h0001, 1'b0, s, co, nb, lat, cseq, s0, b0);
    chk("ripple_cinseq", cseq, 4'b1110);
    step();

    // Back-to-back: second start issued in the DONE cycle.
    run_add(16'h0002, 16'h0002, 1'b1, s, co, nb, lat, cseq, s0, b0);
    chk("b2b_first_sum", s, 16'h0005);
    chk("b2b_first_done", done, 1);
    run_add(16'h0007, 16'h0002, 1'b0, s, co, nb, lat, cseq, s0, b0);
    chk("b2b_no_bubble", b0, 1);
    chk("b2b_clear_sum", s0, 0);
    chk("b2b_second_sum", s, 16'h0009);
    chk("b2b_second_lat", lat, 5);
    step();

    // Start pulsed again during RUN is ignored.
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h1111;
    cin   = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    op_a  = 16'hAAAA;
    op_b  = 16'h5555;
    step();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        last_sum = sum;
      end
      step();
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_sum", last_sum, 16'h2345);

    // Reset in RUN cycle 3 abandons the add.
    start = 1'b1;
    op_a  = 16'h8000;
    op_b  = 16'h8000;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_adder", {adder_a, adder_b, adder_cin}, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) pulses++;
      step();
    end
    chk("mid_rst_quiet", pulses, 0);
    run_add(16'h8000, 16'h8000, 1'b0, s, co, nb, lat, cseq, s0, b0);
    chk("post_rst_sum", s, 16'h0000);
    chk("post_rst_cout", co, 1);

    // Idle: adder ports zero, result held.
    last_sum  = sum;
    last_cout = cout;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      if (adder_a != 0 || adder_b != 0 || adder_cin != 0) bad++;
      if (sum != last_sum || cout != last_cout) bad++;
    end
    chk("idle_hold", bad, 0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      exp17 = ref_add(ra, rb, rc);
      run_add(ra, rb, rc, s, co, nb, lat, cseq, s0, b0);
      chk($sformatf("rnd%0d_res", i), {co, s}, exp17);
      chk($sformatf("rnd%0d_lat", i), lat, 5);
      chk($sformatf("rnd%0d_cinseq", i), cseq, ref_carries(ra, rb, rc));
      if ($urandom_range(1, 0) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two wide operands one nibble at a time through the team's combinational four_bit_adder.
- Sits directly upstream of the adder: drives its A/B/Cin and consumes its S/Cout.
- Holds the inter-nibble carry in a register, assembles the full-width sum, and signals completion.
- Lets one 4-bit adder instance serve 4*NIBBLES-bit additions.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled on rising edge.
- op_a  input  W  operand A; sampled when start is accepted.
- op_b  input  W  operand B; sampled when start is accepted.
- cin  input  1  carry into nibble 0; sampled when start is accepted.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  W  assembled result; held until next accepted start.
- cout  output  1  carry out of the top nibble; held with sum.
- adder_a  output  4  to four_bit_adder A.
- adder_b  output  4  to four_bit_adder B.
- adder_cin  output  1  to four_bit_adder Cin.
- adder_s  input  4  from four_bit_adder S.
- adder_cout  input  1  from four_bit_adder Cout.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a rising edge) has priority over everything:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand regs, nibble index and carry reg cleared.
  - adder_a/adder_b/adder_cin=0.
  - Reset mid-RUN abandons the operation; no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch op_a, op_b; carry reg <= cin; idx <= 0; clear sum; go RUN.
  - RUN: every cycle, on the edge, sum nibble[idx] <= adder_s and carry <= adder_cout.
    - idx < NIBBLES-1: idx++ and stay in RUN.
    - idx = NIBBLES-1: go DONE; cout <= adder_cout.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back, no bubble) -> RUN.
    - Otherwise go IDLE.
- Adder drive:
  - In RUN: adder_a = latched A nibble[idx], adder_b = latched B nibble[idx], adder_cin = carry reg.
  - Outside RUN: all zero.
  - The adder is purely combinational; its result is captured in the same cycle.
- start while in RUN is ignored. op_a/op_b/cin changes after acceptance have no effect.
- busy=1 exactly in RUN.
- Latency: start accepted at edge t -> RUN cycles t+1..t+NIBBLES -> done high in the cycle after edge t+NIBBLES. Total NIBBLES+1 cycles from start to done.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(W+1); no overflow flag.
- sum/cout remain stable from done until the next accepted start, which clears sum to 0.
- NIBBLES=1: single RUN cycle, then DONE.

Test Plan (NIBBLES=4, bench instantiates four_bit_adder as the datapath):
- Reset then op_a=0x0009, op_b=0x000B, cin=0, start 1 cycle -> busy high 4 cycles; done pulses 5 cycles after start; sum=0x0014, cout=0.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, cout=1; per-cycle adder_cin sequence 0,1,1,1.
- op_a=0x0002, op_b=0x0002, cin=1 -> sum=0x0005, cout=0; then 0x0007+0x0002 issued with start during the DONE cycle -> accepted with no idle cycle; sum=0x0009.
- Start a 0x1234+0x1111 add, pulse start again with 0xAAAA+0x5555 in RUN cycle 2 -> second start ignored; sum=0x2345, single done pulse.
- Start 0x8000+0x8000, assert rst in RUN cycle 3 -> next cycle: busy=0, sum=0, cout=0, adder ports 0; no done pulse. A fresh start afterwards gives sum=0x0000, cout=1.
- Idle check: with no start, adder_a/adder_b/adder_cin stay 0 and sum/cout hold their last value for 20 cycles.
